// File: rtl/axis_window_scheduler_if.sv
// Trigger/length link from the scheduler to the downstream gated-window block.
// win_trig is a one-cycle tvalid pulse with no ready: the window block accepts it or ignores it while busy.
interface axis_window_scheduler_if;
  logic       win_trig;
  logic [7:0] win_len;

  modport master (output win_trig, win_len);
  modport slave  (input  win_trig, win_len);
endinterface

// File: rtl/axis_window_scheduler.sv
// Issues a burst of N trigger pulses to a gated-window block, spaced so the downstream windows never overlap.
// Pacing comes from an internal period timer or from rising edges on ext_trig.
module axis_window_scheduler #(
  parameter int CNTR_WIDTH = 32,
  parameter int NUM_WIDTH  = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [7:0]            cfg_len,
  input  logic [CNTR_WIDTH-1:0] cfg_period,
  input  logic [NUM_WIDTH-1:0]  cfg_number,
  input  logic                  cfg_ext,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  ext_trig,
  axis_window_scheduler_if.master win,
  output logic [NUM_WIDTH-1:0]  sts_count,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {IDLE, ARM, FIRE, HOLD, DRAIN} state_t;

  state_t                state;
  logic                  start_q;
  logic                  ext_q;
  logic                  start_edge;
  logic                  ext_edge;
  logic [CNTR_WIDTH-1:0] cnt;
  logic [CNTR_WIDTH-1:0] p_eff;
  logic [CNTR_WIDTH-1:0] len_plus2;
  logic [CNTR_WIDTH-1:0] p_calc;
  logic [NUM_WIDTH-1:0]  n_lat;
  logic                  ext_lat;
  logic [NUM_WIDTH-1:0]  sts_inc;

  assign start_edge = start & ~start_q;
  assign ext_edge   = ext_trig & ~ext_q;
  assign dbg_state  = state;

  // A window needs L+1 cycles plus one idle cycle before it can be retriggered.
  assign len_plus2 = CNTR_WIDTH'(cfg_len) + CNTR_WIDTH'(2);
  assign p_calc    = (cfg_period > len_plus2) ? cfg_period : len_plus2;
  assign sts_inc   = (sts_count == n_lat) ? sts_count : sts_count + NUM_WIDTH'(1);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state        <= IDLE;
      start_q      <= 1'b0;
      ext_q        <= 1'b0;
      cnt          <= '0;
      p_eff        <= '0;
      n_lat        <= '0;
      ext_lat      <= 1'b0;
      win.win_trig <= 1'b0;
      win.win_len  <= '0;
      sts_count    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      start_q      <= start;
      ext_q        <= ext_trig;
      win.win_trig <= 1'b0;
      if (abort) begin
        state <= IDLE;
        busy  <= 1'b0;
        done  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start_edge) begin
              if (cfg_number == '0) begin
                done      <= 1'b1;
                sts_count <= '0;
              end else begin
                win.win_len <= cfg_len;
                n_lat       <= cfg_number;
                ext_lat     <= cfg_ext;
                p_eff       <= p_calc;
                busy        <= 1'b1;
                done        <= 1'b0;
                if (cfg_ext) begin
                  state     <= ARM;
                  sts_count <= '0;
                end else begin
                  state        <= FIRE;
                  win.win_trig <= 1'b1;
                  sts_count    <= NUM_WIDTH'(1);
                end
              end
            end
          end
          ARM: begin
            if (ext_edge) begin
              state        <= FIRE;
              win.win_trig <= 1'b1;
              sts_count    <= sts_inc;
            end
          end
          FIRE: begin
            if (sts_count == n_lat) begin
              cnt   <= CNTR_WIDTH'(win.win_len) + CNTR_WIDTH'(1);
              state <= DRAIN;
            end else begin
              cnt   <= p_eff - CNTR_WIDTH'(1);
              state <= HOLD;
            end
          end
          HOLD: begin
            cnt <= cnt - CNTR_WIDTH'(1);
            // Leaving on cnt==1 makes the pulse land exactly P_eff cycles after the previous one.
            if (cnt == CNTR_WIDTH'(1)) begin
              if (ext_lat) begin
                state <= ARM;
              end else begin
                state        <= FIRE;
                win.win_trig <= 1'b1;
                sts_count    <= sts_inc;
              end
            end
          end
          DRAIN: begin
            cnt <= cnt - CNTR_WIDTH'(1);
            if (cnt == CNTR_WIDTH'(1)) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
